// File: rtl/risc16_boot_pkg.sv
// Shared definitions for the RiSC16 boot sequencer: state encoding, default
// timing and RiSC16 opcodes for building program words.
package risc16_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PURGE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_BOOT  = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  localparam int DEFAULT_RESET_CYCLES = 2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  // RRI-format word: opcode, regA, regB, signed 7-bit immediate
  function automatic logic [15:0] rri_word(input logic [2:0] op, input logic [2:0] ra,
                                           input logic [2:0] rb, input logic [6:0] imm);
    return {op, ra, rb, imm};
  endfunction

endpackage

// File: rtl/risc16_cycle_timer.sv
// Loadable down-counter; done is high while the count equals one, so a state
// that loads it exits after exactly load_value cycles.
module risc16_cycle_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign done = (count_reg == WIDTH'(1));

endmodule

// File: rtl/risc16_boot_sequencer.sv
// Programs, resets and releases a RiSC16 system: purge under reset, stream
// host words onto pen/instr, pulse a boot reset, then hold the system running.
module risc16_boot_sequencer
  import risc16_boot_pkg::*;
#(
  parameter int WORD_LENGTH  = 16,
  parameter int MAX_WORDS    = 256,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           wr_valid,
  input  logic [WORD_LENGTH-1:0]         wr_data,
  input  logic                           wr_last,
  output logic                           wr_ready,
  output logic                           sys_pen,
  output logic [WORD_LENGTH-1:0]         sys_instr,
  output logic                           sys_rst,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count,
  output logic                           busy,
  output logic                           running,
  output logic                           error
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  state_t                  state_reg, state_next;
  logic                    sys_rst_reg, sys_rst_next;
  logic                    sys_pen_reg, sys_pen_next;
  logic [WORD_LENGTH-1:0]  sys_instr_reg, sys_instr_next;
  logic [CW-1:0]           word_count_reg, word_count_next;
  logic                    error_reg, error_next;
  logic                    timer_load;
  logic                    timer_done;
  logic                    xfer;

  risc16_cycle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (timer_load),
    .load_value(TW'(RESET_CYCLES)),
    .done      (timer_done)
  );

  assign wr_ready = (state_reg == ST_LOAD);
  assign busy     = (state_reg == ST_PURGE) || (state_reg == ST_LOAD) ||
                    (state_reg == ST_DRAIN) || (state_reg == ST_BOOT);
  assign running  = (state_reg == ST_RUN);
  assign xfer     = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      sys_rst_reg    <= 1'b1;
      sys_pen_reg    <= 1'b0;
      sys_instr_reg  <= '0;
      word_count_reg <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sys_rst_reg    <= sys_rst_next;
      sys_pen_reg    <= sys_pen_next;
      sys_instr_reg  <= sys_instr_next;
      word_count_reg <= word_count_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sys_rst_next    = sys_rst_reg;
    sys_pen_next    = 1'b0;
    sys_instr_next  = sys_instr_reg;
    word_count_next = word_count_reg;
    error_next      = error_reg;
    timer_load      = 1'b0;

    case (state_reg)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        sys_rst_next = (state_reg != ST_RUN);
        if (start) begin
          state_next      = ST_PURGE;
          word_count_next = '0;
          error_next      = 1'b0;
          timer_load      = 1'b1;
          sys_rst_next    = 1'b1;
          sys_pen_next    = 1'b1;
        end
      end
      ST_PURGE: begin
        sys_rst_next = 1'b1;
        sys_pen_next = 1'b1;
        if (timer_done) begin
          state_next   = ST_LOAD;
          sys_rst_next = 1'b0;
          sys_pen_next = 1'b0;
        end
      end
      ST_LOAD: begin
        sys_rst_next = 1'b0;
        if (xfer) begin
          // A full program plus one more word is an overflow: drop it, park in ERROR
          if (word_count_reg == MAX_CNT) begin
            state_next   = ST_ERROR;
            error_next   = 1'b1;
            sys_rst_next = 1'b1;
          end else begin
            sys_pen_next    = 1'b1;
            sys_instr_next  = wr_data;
            word_count_next = word_count_reg + CW'(1);
            if (wr_last) begin
              state_next = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        state_next   = ST_BOOT;
        sys_rst_next = 1'b1;
        timer_load   = 1'b1;
      end
      ST_BOOT: begin
        sys_rst_next = 1'b1;
        if (timer_done) begin
          state_next   = ST_RUN;
          sys_rst_next = 1'b0;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        sys_rst_next = 1'b1;
      end
    endcase
  end

  assign sys_rst    = sys_rst_reg;
  assign sys_pen    = sys_pen_reg;
  assign sys_instr  = sys_instr_reg;
  assign word_count = word_count_reg;
  assign error      = error_reg;

endmodule

// File: doc/risc16_boot_sequencer.md
Name: risc16_boot_sequencer

Overview:
- Controller that programs, resets and releases the RiSC16 single-cycle system.
- Drives the system's pen, instr and rst inputs, replacing hand-timed testbench sequencing.
- Accepts instruction words from a host over a valid/ready stream.
- Sequence: purge with system in reset, stream program words in, pulse a boot reset, then hold the system in run until a new start.

Parameters:
WORD_LENGTH, 16, instruction word width; matches system WORD_LENGTH
MAX_WORDS, 256, maximum program length in words
RESET_CYCLES, 2, clock cycles sys_rst is held high in PURGE and BOOT; must be >=1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request (re)programming; single-cycle pulse or level
wr_valid  input  1  host word valid
wr_data  input  WORD_LENGTH  host instruction word
wr_last  input  1  qualifies wr_data as final program word
wr_ready  output  1  sequencer accepts a word this cycle
sys_pen  output  1  program enable to system
sys_instr  output  WORD_LENGTH  instruction word to system
sys_rst  output  1  system reset, active-high
word_count  output  clog2(MAX_WORDS+1)  words forwarded since last start
busy  output  1  state is PURGE, LOAD, DRAIN or BOOT
running  output  1  state is RUN
error  output  1  overflow detected; sticky until next start

Behaviour:
- All outputs registered except wr_ready, busy and running, which decode from state.
- Reset (rst=0), asynchronous:
  - state=IDLE, sys_rst=1, sys_pen=0, sys_instr=0, word_count=0, error=0.
  - The system is held in reset until programmed.
- States: IDLE, PURGE, LOAD, DRAIN, BOOT, RUN, ERROR.
- IDLE: sys_rst=1, sys_pen=0. On start, go to PURGE, clear word_count and error, load timer=RESET_CYCLES.
- PURGE: sys_rst=1, sys_pen=1 for exactly RESET_CYCLES cycles, then go to LOAD with sys_rst=0, sys_pen=0.
- LOAD: wr_ready=1. A transfer is wr_valid&wr_ready at a rising edge.
  - Transfer at edge N: sys_instr=wr_data and sys_pen=1 during cycle N..N+1 (1-cycle latency); word_count increments.
  - No transfer: sys_pen=0 and sys_instr holds its last value. Each word produces exactly one sys_pen cycle.
  - Transfer with wr_last: go to DRAIN.
- DRAIN (1 cycle): wr_ready=0. The last word is still presented (sys_pen=1). Next edge: BOOT, sys_pen=0, sys_rst=1, timer=RESET_CYCLES.
- BOOT: sys_rst=1, sys_pen=0 for RESET_CYCLES cycles, then go to RUN with sys_rst=0.
- RUN: sys_rst=0, sys_pen=0, running=1. start goes to PURGE (reprogram).
- Overflow: a transfer attempted in LOAD with word_count==MAX_WORDS:
  - the word is not forwarded (sys_pen=0) and word_count saturates;
  - error=1, go to ERROR.
- ERROR: sys_rst=1, sys_pen=0, wr_ready=0. start goes to PURGE and clears error.
- start is ignored in PURGE, LOAD, DRAIN and BOOT.
- wr_valid outside LOAD is ignored; no transfer occurs.
- Asynchronous reset mid-LOAD: all progress is discarded and the block returns to IDLE with the system in reset.
- Timer is a down-counter of width clog2(RESET_CYCLES+1). A state exits when the timer reaches 1 at an edge.

Decomposition:
- Shared package risc16_boot_pkg holds:
  - state encoding localparams (3-bit: IDLE=0, PURGE=1, LOAD=2, DRAIN=3, BOOT=4, RUN=5, ERROR=6);
  - default RESET_CYCLES;
  - RiSC16 opcode constants for bench program construction.
- One natural sub-module: risc16_cycle_timer, a loadable down-counter with a done flag, shared by PURGE and BOOT.

Test Plan:
- Reset, then idle 5 cycles -> sys_rst=1, sys_pen=0, sys_instr=0, word_count=0, busy=0, running=0.
- Run the bench with RESET_CYCLES=2:
  - Stimulus: start pulse, then stream 0x6B00 and 0x6D00 (lui 2,0x300; lui 3,0x100), wr_last on the second.
  - Required: sys_rst=1/sys_pen=1 for 2 cycles; 0x6B00 then 0x6D00 each with exactly one sys_pen cycle; DRAIN; sys_rst=1/pen=0 for 2 cycles; then running=1, sys_rst=0, word_count=2.
- Gaps in LOAD: wr_valid low for 3 cycles between words -> sys_pen=0 in gaps, sys_instr holds 0x6B00, no extra count.
- Overflow with MAX_WORDS=4: stream 5 words -> fifth not forwarded, word_count=4, error=1, state ERROR with sys_rst=1; a start then clears error and enters PURGE.
- Reset asserted mid-LOAD after 1 word -> immediate IDLE, sys_rst=1, word_count=0. start in LOAD or BOOT has no effect; start in RUN restarts PURGE.
